// File: rtl/dma_burst_engine.sv
// Burst DMA engine: copies (mode 0) or pattern-fills (mode 1) `size` cache lines,
// issuing read/write bursts of at most MAX_BURST lines and reporting progress.
module dma_burst_engine #(
  parameter int ADDR_WIDTH  = 64,
  parameter int SIZE_WIDTH  = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int MAX_BURST   = 16,
  parameter int BURST_WIDTH = 16,
  parameter int CL_BYTES    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic                   mode,
  input  logic [63:0]            pattern,
  input  logic [ADDR_WIDTH-1:0]  cfg_rd_addr,
  input  logic [ADDR_WIDTH-1:0]  cfg_wr_addr,
  input  logic [SIZE_WIDTH-1:0]  size,
  output logic                   done,
  output logic                   busy,
  output logic [SIZE_WIDTH-1:0]  lines_done,
  output logic [ADDR_WIDTH-1:0]  dma_rd_addr,
  output logic [BURST_WIDTH-1:0] dma_rd_size,
  output logic                   dma_rd_go,
  output logic                   dma_rd_en,
  input  logic                   dma_empty,
  input  logic [DATA_WIDTH-1:0]  dma_rd_data,
  input  logic                   dma_rd_done,
  output logic [ADDR_WIDTH-1:0]  dma_wr_addr,
  output logic [BURST_WIDTH-1:0] dma_wr_size,
  output logic                   dma_wr_go,
  output logic                   dma_wr_en,
  input  logic                   dma_full,
  output logic [DATA_WIDTH-1:0]  dma_wr_data,
  input  logic                   dma_wr_done
);

  localparam int LANES = DATA_WIDTH / 64;
  localparam logic [SIZE_WIDTH-1:0] MAX_BURST_S = SIZE_WIDTH'(MAX_BURST);

  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DRAIN, FINISH} state_t;
  state_t state_reg, state_next;

  logic                   mode_reg;
  logic [63:0]            pattern_reg;
  logic [ADDR_WIDTH-1:0]  rd_addr_reg, wr_addr_reg;
  logic [SIZE_WIDTH-1:0]  remaining_reg, lines_done_reg;
  logic [BURST_WIDTH-1:0] blen_reg, burst_left_reg;
  logic [1:0]             guard_reg;
  logic                   done_reg, busy_reg, rd_go_reg, wr_go_reg;
  logic [ADDR_WIDTH-1:0]  dma_rd_addr_reg, dma_wr_addr_reg;
  logic [BURST_WIDTH-1:0] dma_size_reg;

  logic [SIZE_WIDTH-1:0]  blen_next;
  logic                   rd_en_next, wr_en_next, done_ok;
  logic [ADDR_WIDTH-1:0]  addr_inc;
  logic [63:0]            fill_word;
  logic [DATA_WIDTH-1:0]  fill_data;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    blen_next  = (remaining_reg < MAX_BURST_S) ? remaining_reg : MAX_BURST_S;
    rd_en_next = 1'b0;
    wr_en_next = 1'b0;
    // A pop is only taken when the line can be pushed in the same cycle.
    if (state_reg == STREAM && burst_left_reg != '0) begin
      if (mode_reg) begin
        wr_en_next = !dma_full;
      end else begin
        wr_en_next = !dma_empty && !dma_full;
        rd_en_next = wr_en_next;
      end
    end
    done_ok    = (guard_reg == 2'd0) && dma_wr_done && (mode_reg || dma_rd_done);
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go) state_next = (size == '0) ? FINISH : ISSUE;
      ISSUE:   state_next = STREAM;
      STREAM:  if (burst_left_reg == '0) state_next = DRAIN;
      DRAIN:   if (done_ok) state_next = (remaining_reg == '0) ? FINISH : ISSUE;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign addr_inc = ADDR_WIDTH'(blen_reg) * ADDR_WIDTH'(CL_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg        <= 1'b0;
      pattern_reg     <= '0;
      rd_addr_reg     <= '0;
      wr_addr_reg     <= '0;
      remaining_reg   <= '0;
      lines_done_reg  <= '0;
      blen_reg        <= '0;
      burst_left_reg  <= '0;
      guard_reg       <= 2'd0;
      done_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      rd_go_reg       <= 1'b0;
      wr_go_reg       <= 1'b0;
      dma_rd_addr_reg <= '0;
      dma_wr_addr_reg <= '0;
      dma_size_reg    <= '0;
    end else begin
      rd_go_reg <= 1'b0;
      wr_go_reg <= 1'b0;
      if (guard_reg != 2'd0) guard_reg <= guard_reg - 2'd1;
      case (state_reg)
        IDLE: begin
          if (go) begin
            mode_reg       <= mode;
            pattern_reg    <= pattern;
            rd_addr_reg    <= cfg_rd_addr;
            wr_addr_reg    <= cfg_wr_addr;
            remaining_reg  <= size;
            lines_done_reg <= '0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end
        ISSUE: begin
          dma_rd_addr_reg <= rd_addr_reg;
          dma_wr_addr_reg <= wr_addr_reg;
          dma_size_reg    <= BURST_WIDTH'(blen_next);
          blen_reg        <= BURST_WIDTH'(blen_next);
          burst_left_reg  <= BURST_WIDTH'(blen_next);
          wr_go_reg       <= 1'b1;
          rd_go_reg       <= !mode_reg;
          // Masks done levels still held high from the previous burst.
          guard_reg       <= 2'd2;
        end
        STREAM: begin
          if (wr_en_next) begin
            burst_left_reg <= burst_left_reg - BURST_WIDTH'(1);
            remaining_reg  <= remaining_reg - SIZE_WIDTH'(1);
            if (lines_done_reg != '1) lines_done_reg <= lines_done_reg + SIZE_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (done_ok) begin
            rd_addr_reg <= rd_addr_reg + addr_inc;
            wr_addr_reg <= wr_addr_reg + addr_inc;
          end
        end
        FINISH: begin
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign fill_word = pattern_reg + 64'(lines_done_reg);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign fill_data[gi*64 +: 64] = fill_word;
    end
  endgenerate

  assign dma_wr_data = (state_reg != STREAM) ? '0 : (mode_reg ? fill_data : dma_rd_data);
  assign dma_rd_en   = rd_en_next;
  assign dma_wr_en   = wr_en_next;
  assign done        = done_reg;
  assign busy        = busy_reg;
  assign lines_done  = lines_done_reg;
  assign dma_rd_addr = dma_rd_addr_reg;
  assign dma_wr_addr = dma_wr_addr_reg;
  assign dma_rd_size = dma_size_reg;
  assign dma_wr_size = dma_size_reg;
  assign dma_rd_go   = rd_go_reg;
  assign dma_wr_go   = wr_go_reg;

endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine with a behavioural DMA channel responder
// and queue-based scoreboards for burst descriptors and written lines.
module tb_dma_burst_engine;

  logic         clk, rst, go, mode;
  logic [63:0]  pattern, cfg_rd_addr, cfg_wr_addr;
  logic [31:0]  size;
  logic         done, busy;
  logic [31:0]  lines_done;
  logic [63:0]  dma_rd_addr, dma_wr_addr;
  logic [15:0]  dma_rd_size, dma_wr_size;
  logic         dma_rd_go, dma_rd_en, dma_empty, dma_rd_done;
  logic         dma_wr_go, dma_wr_en, dma_full, dma_wr_done;
  logic [511:0] dma_rd_data, dma_wr_data;

  dma_burst_engine dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .pattern(pattern),
    .cfg_rd_addr(cfg_rd_addr), .cfg_wr_addr(cfg_wr_addr), .size(size),
    .done(done), .busy(busy), .lines_done(lines_done),
    .dma_rd_addr(dma_rd_addr), .dma_rd_size(dma_rd_size), .dma_rd_go(dma_rd_go),
    .dma_rd_en(dma_rd_en), .dma_empty(dma_empty), .dma_rd_data(dma_rd_data),
    .dma_rd_done(dma_rd_done),
    .dma_wr_addr(dma_wr_addr), .dma_wr_size(dma_wr_size), .dma_wr_go(dma_wr_go),
    .dma_wr_en(dma_wr_en), .dma_full(dma_full), .dma_wr_data(dma_wr_data),
    .dma_wr_done(dma_wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd_addr;
    logic [63:0] wr_addr;
    int unsigned len;
    bit          copy;
  } burst_t;

  burst_t       burst_q[$];
  logic [511:0] exp_q[$];
  burst_t       cur_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int rd_go_cnt = 0, wr_go_cnt = 0, done_rise = 0;
  int rd_avail = 0, wr_left = 0, rd_done_cnt = 0, wr_done_cnt = 0;
  int unsigned rd_idx = 0;
  bit rd_clr = 0, wr_clr = 0, done_q = 0, cur_copy = 1, stall_en = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkdata(input int unsigned idx);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = {idx, 32'hC0DE0000 | 32'(k)};
    return d;
  endfunction

  // DMA channel responder: drives inputs at negedge, observes DUT strobes 1 time unit later.
  initial begin
    dma_empty = 1'b1; dma_full = 1'b0; dma_rd_data = '0;
    dma_rd_done = 1'b0; dma_wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_clr) begin dma_rd_done = 1'b0; rd_clr = 0; end
      if (wr_clr) begin dma_wr_done = 1'b0; wr_clr = 0; end
      if (rd_done_cnt != 0) begin rd_done_cnt--; if (rd_done_cnt == 0) dma_rd_done = 1'b1; end
      if (wr_done_cnt != 0) begin wr_done_cnt--; if (wr_done_cnt == 0) dma_wr_done = 1'b1; end
      dma_full    = stall_en && ($urandom_range(0, 2) == 0);
      dma_empty   = (rd_avail == 0) || (stall_en && ($urandom_range(0, 2) == 0));
      dma_rd_data = mkdata(rd_idx);
      #1;
      if (rst) begin
        rd_avail = 0; wr_left = 0; rd_done_cnt = 0; wr_done_cnt = 0;
        rd_clr = 0; wr_clr = 0; done_q = 0;
        dma_rd_done = 1'b0; dma_wr_done = 1'b0;
        exp_q.delete();
      end else begin
        if (dma_rd_go) rd_go_cnt++;
        if (dma_wr_go) begin
          wr_go_cnt++;
          if (burst_q.size() == 0) begin
            chk("unexpected_wr_go", 1, 0);
          end else begin
            cur_b = burst_q.pop_front();
            chk("prev_burst_complete", wr_left, 0);
            chk("wr_addr", dma_wr_addr, cur_b.wr_addr);
            chk("wr_size", dma_wr_size, cur_b.len);
            chk("rd_go_with_wr_go", dma_rd_go, cur_b.copy);
            if (cur_b.copy) begin
              chk("rd_addr", dma_rd_addr, cur_b.rd_addr);
              chk("rd_size", dma_rd_size, cur_b.len);
              rd_avail += int'(cur_b.len);
              rd_clr = 1;
            end
            wr_left = int'(cur_b.len);
            wr_clr = 1;
          end
        end else if (dma_rd_go) begin
          chk("rd_go_without_wr_go", 1, 0);
        end
        if (dma_rd_en) begin
          chk("rd_en_legal", {cur_copy, dma_empty, dma_full}, 3'b100);
          exp_q.push_back(dma_rd_data);
          rd_idx++;
          if (rd_avail > 0) rd_avail--;
          if (rd_avail == 0) rd_done_cnt = 2;
        end
        if (dma_wr_en) begin
          chk("wr_en_not_full", dma_full, 0);
          chk("wr_within_burst", wr_left > 0, 1);
          if (cur_copy) chk("rd_wr_en_pair", dma_rd_en, 1);
          if (exp_q.size() == 0) chk("wr_data_unexpected", 1, 0);
          else chk("wr_data", dma_wr_data, exp_q.pop_front());
          if (wr_left > 0) wr_left--;
          if (wr_left == 0) wr_done_cnt = 2;
        end else if (dma_rd_en) begin
          chk("rd_without_wr", 1, 0);
        end
        if (done && !done_q) done_rise++;
        done_q = done;
      end
    end
  end

  task automatic plan(input bit copy, input logic [63:0] pat, input logic [63:0] ra,
                      input logic [63:0] wa, input int unsigned sz, output int nb);
    int unsigned rem, blen;
    burst_t e;
    rem = sz; nb = 0;
    while (rem > 0) begin
      blen = (rem < 16) ? rem : 16;
      e.rd_addr = ra; e.wr_addr = wa; e.len = blen; e.copy = copy;
      burst_q.push_back(e);
      ra = ra + 64'(blen) * 64'd64;
      wa = wa + 64'(blen) * 64'd64;
      rem -= blen;
      nb++;
    end
    if (!copy) for (int i = 0; i < int'(sz); i++) exp_q.push_back({8{pat + 64'(i)}});
  endtask

  task automatic start(input bit copy, input logic [63:0] pat, input logic [63:0] ra,
                       input logic [63:0] wa, input int unsigned sz, input bit stall);
    cur_copy = copy; stall_en = stall;
    @(negedge clk);
    go = 1'b1; mode = !copy; pattern = pat;
    cfg_rd_addr = ra; cfg_wr_addr = wa; size = sz;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run(input bit copy, input logic [63:0] pat, input logic [63:0] ra,
                     input logic [63:0] wa, input int unsigned sz, input bit stall,
                     input bit extra_go);
    int nb, rgo0, wgo0, dr0;
    plan(copy, pat, ra, wa, sz, nb);
    rgo0 = rd_go_cnt; wgo0 = wr_go_cnt; dr0 = done_rise;
    start(copy, pat, ra, wa, sz, stall);
    #2;
    chk("busy_after_go", busy, 1);
    chk("done_cleared", done, 0);
    chk("lines_done_cleared", lines_done, 0);
    chk("wr_go_not_early", dma_wr_go, 0);
    @(negedge clk); #2;
    if (sz == 0) chk("size0_done_2cyc", {done, busy}, 2'b10);
    else chk("wr_go_latency_2cyc", dma_wr_go, 1);
    if (extra_go) begin
      @(negedge clk);
      go = 1'b1; size = 5; cfg_wr_addr = 64'hDEAD_0000;
      @(negedge clk);
      go = 1'b0;
    end
    for (int i = 0; i < 4000 && !(done === 1'b1 && busy === 1'b0); i++) @(negedge clk);
    #2;
    chk("completion", {done, busy}, 2'b10);
    chk("lines_done", lines_done, sz);
    chk("done_once", done_rise - dr0, 1);
    chk("rd_go_count", rd_go_cnt - rgo0, copy ? nb : 0);
    chk("wr_go_count", wr_go_cnt - wgo0, nb);
    chk("bursts_left", burst_q.size(), 0);
    chk("lines_left", exp_q.size(), 0);
    $display("transfer copy=%0d size=%0d bursts=%0d lines_done=%0d done=%0d",
             copy, sz, wr_go_cnt - wgo0, lines_done, done);
    repeat (3) @(negedge clk);
    #2 chk("done_held", done, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {done, busy, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en}, 6'b0);
    chk({tag, "_lines"}, lines_done, 0);
    chk({tag, "_addr"}, {dma_rd_addr, dma_wr_addr}, 128'b0);
    chk({tag, "_size"}, {dma_rd_size, dma_wr_size}, 32'b0);
    chk({tag, "_data"}, dma_wr_data, 512'b0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; mode = 1'b0; pattern = '0;
    cfg_rd_addr = '0; cfg_wr_addr = '0; size = '0;
    repeat (3) @(negedge clk);
    #2 chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    #2 chk("idle_not_busy", busy, 0);

    run(1'b1, 64'h0, 64'h1000, 64'h2000, 1, 1'b0, 1'b0);
    run(1'b1, 64'h0, 64'h1000, 64'h2000, 40, 1'b0, 1'b0);
    run(1'b0, 64'hFF, 64'h0, 64'h3000, 3, 1'b0, 1'b0);
    run(1'b1, 64'h0, 64'h5000, 64'h9000, 33, 1'b1, 1'b0);
    run(1'b1, 64'h0, 64'h100, 64'h200, 0, 1'b0, 1'b0);
    run(1'b1, 64'h0, 64'h7000, 64'h8000, 20, 1'b0, 1'b1);
    run(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'hFFFF_FFFF_FFFF_FC00, 20, 1'b1, 1'b0);

    begin
      int nb;
      plan(1'b1, 64'h0, 64'h1000, 64'h2000, 40, nb);
      start(1'b1, 64'h0, 64'h1000, 64'h2000, 40, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2 chk_reset_outputs("mid_burst_reset");
      rst = 1'b0;
      burst_q.delete();
      exp_q.delete();
    end
    run(1'b1, 64'h0, 64'hA000, 64'hB000, 17, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dma_burst_engine.md
Name: dma_burst_engine

Overview:
- Parametrised successor to the single-line DMA loopback path in the AFU.
- Copies `size` cache lines from a read base address to a write base address over the DMA interface.
- Splits large transfers into bursts of at most MAX_BURST lines, and adds a write-only pattern-fill mode.
- Sits between memory_map (go/addresses/size/mode) and the DMA read/write channels, and returns done plus progress to software.

Parameters:
- ADDR_WIDTH, 64, virtual byte address width.
- SIZE_WIDTH, 32, width of total line count.
- DATA_WIDTH, 512, cache-line width in bits.
- MAX_BURST, 16, maximum lines per DMA burst (power of 2, ≥1).
- BURST_WIDTH, 16, width of dma rd_size/wr_size.
- CL_BYTES, 64, bytes per cache line (address increment unit).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- go  in  1  start request from memory_map (level; acted on in IDLE only)
- mode  in  1  0=copy, 1=fill
- pattern  in  64  fill seed (mode 1)
- cfg_rd_addr  in  ADDR_WIDTH  read base byte address
- cfg_wr_addr  in  ADDR_WIDTH  write base byte address
- size  in  SIZE_WIDTH  total lines
- done  out  1  transfer complete, held
- busy  out  1  transfer in progress
- lines_done  out  SIZE_WIDTH  lines written so far
- dma_rd_addr  out  ADDR_WIDTH  burst read address
- dma_rd_size  out  BURST_WIDTH  burst read length
- dma_rd_go  out  1  one-cycle burst read start
- dma_rd_en  out  1  pop read data
- dma_empty  in  1  read data unavailable
- dma_rd_data  in  DATA_WIDTH  read data
- dma_rd_done  in  1  read burst complete (level)
- dma_wr_addr  out  ADDR_WIDTH  burst write address
- dma_wr_size  out  BURST_WIDTH  burst write length
- dma_wr_go  out  1  one-cycle burst write start
- dma_wr_en  out  1  push write data
- dma_full  in  1  write channel full
- dma_wr_data  out  DATA_WIDTH  write data
- dma_wr_done  in  1  write burst complete (level)

Behaviour:
- Reset: all outputs 0 (done=0, busy=0, lines_done=0, go pulses 0, addresses/sizes 0); FSM→IDLE. Reset mid-transfer aborts immediately; no further DMA strobes.
- IDLE: on go=1, latch mode, pattern, both addresses, and size into working registers; clear done and lines_done; busy=1.
  - size==0: go to FINISH directly; no DMA activity.
  - Otherwise → ISSUE.
  - go while not IDLE is ignored.
- ISSUE (1 cycle):
  - blen = min(remaining, MAX_BURST). Drive dma_rd_addr/dma_wr_addr = current addresses and dma_rd_size/dma_wr_size = blen.
  - Pulse dma_wr_go. Pulse dma_rd_go only if mode=0.
  - burst_left=blen; guard counter=2 → STREAM.
- Address and size outputs are registered and stable from ISSUE through the burst.
- STREAM:
  - mode 0: dma_rd_en = dma_wr_en = !dma_empty && !dma_full && burst_left≠0; dma_wr_data = dma_rd_data, same cycle (combinational pass-through).
  - mode 1: dma_rd_en=0; dma_wr_en = !dma_full && burst_left≠0; dma_wr_data = 8 replicas of (pattern + lines_done), 64-bit wrap-around add, lane 0 in bits [63:0].
  - Each cycle with wr_en: burst_left−1, lines_done+1, remaining−1.
  - burst_left==0 → DRAIN.
- DRAIN: guard counter decrements each cycle from ISSUE. It masks stale done levels from the previous burst.
  - Once the guard is 0, wait for dma_wr_done=1 and (mode=1 or dma_rd_done=1).
  - Then: rd_addr += blen*CL_BYTES, wr_addr += blen*CL_BYTES (ADDR_WIDTH wrap-around, no error).
  - remaining≠0 → ISSUE; else → FINISH.
- FINISH: done=1, busy=0 (registered, 1 cycle after entry) → IDLE. done holds until the next accepted go or reset.
- Simultaneous dma_empty=0 and dma_full=1 in mode 0: no pop. Read data stays in the DMA channel.
- lines_done saturates at SIZE_WIDTH max (unreachable in practice). Last burst may be shorter than MAX_BURST.
- Latency: go→first dma_wr_go = 2 cycles. Last wr_en→done ≥ 3 cycles (guard + done wait + FINISH).

Test Plan:
- Copy, size=1, rd=0x1000, wr=0x2000, no backpressure → one ISSUE with rd/wr_size=1; one rd_en/wr_en with wr_data==rd_data; done=1; lines_done=1.
- Copy, size=40, MAX_BURST=16 → bursts of 16,16,8 at rd addrs 0x1000, 0x1400, 0x1800 (wr addrs likewise, +0x400 per 16-line burst); lines_done=40; done exactly once.
- Fill, size=3, pattern=0xFF → no dma_rd_go or rd_en; wr_data lanes = 0xFF, 0x100, 0x101 across the 3 lines.
- Random dma_empty/dma_full toggling over size=33 → no wr_en while full, no rd_en while empty or full; data order preserved; rd_done/wr_done held high from prior burst are not accepted during the guard.
- size=0 → done after 2 cycles; no DMA go pulses. A second go during busy is ignored.
- Reset asserted mid-burst → next cycle all outputs 0, FSM IDLE. A new go then runs a full transfer correctly.
